// File: rtl/fp_pkg.sv
// Floating-point format, sequencer states and classification helpers
// shared by the add/subtract sequencer and its datapath.
package fp;

    localparam int EXP_BITS      = 8;
    localparam int FRACTION_BITS = 23;

    typedef struct packed {
        logic                     sign;
        logic [EXP_BITS-1:0]      exp;
        logic [FRACTION_BITS-1:0] frac;
    } float;

    localparam logic [EXP_BITS-1:0] EXP_MAX = '1;
    localparam float QNAN = '{sign: 1'b0, exp: EXP_MAX,
                              frac: {1'b1, {(FRACTION_BITS-1){1'b0}}}};

    typedef enum logic [2:0] {IDLE, SWAP, ALIGN, SUM, NORM, DONE} seq_state_t;

    function automatic logic is_nan(input float x);
        return (x.exp == EXP_MAX) && (x.frac != '0);
    endfunction

    function automatic logic is_inf(input float x);
        return (x.exp == EXP_MAX) && (x.frac == '0);
    endfunction

    // Denormals are flushed, so any zero exponent counts as zero.
    function automatic logic is_zero(input float x);
        return x.exp == '0;
    endfunction

endpackage

// File: rtl/fp_add_datapath.sv
// Significand/exponent registers for one add/subtract, with a single adder
// and a single 1-bit normalize shifter steered by the sequencer's enables.
module fp_add_datapath
    import fp::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     align_shift,
    input  logic                     align_clear,
    input  logic                     sum_en,
    input  logic                     norm_right,
    input  logic                     norm_left,
    input  float                     op_a,
    input  float                     op_b,
    output logic [EXP_BITS-1:0]      d,
    output logic [FRACTION_BITS:0]   small_sig,
    output logic [FRACTION_BITS+1:0] sum,
    output logic [EXP_BITS-1:0]      exp,
    output logic                     sign
);

    logic [FRACTION_BITS:0]   big_sig;
    logic                     eff_sub;
    logic                     a_big;
    float                     big_op;
    float                     small_op;
    logic [FRACTION_BITS+1:0] adder_out;
    logic [FRACTION_BITS+1:0] shift_out;

    function automatic logic [FRACTION_BITS:0] sig_of(input float x);
        return is_zero(x) ? '0 : {1'b1, x.frac};
    endfunction

    always_comb begin
        a_big     = {op_a.exp, op_a.frac} >= {op_b.exp, op_b.frac};
        big_op    = a_big ? op_a : op_b;
        small_op  = a_big ? op_b : op_a;
        adder_out = eff_sub ? ({1'b0, big_sig} - {1'b0, small_sig})
                            : ({1'b0, big_sig} + {1'b0, small_sig});
        shift_out = norm_right ? {1'b0, sum[FRACTION_BITS+1:1]}
                               : {sum[FRACTION_BITS:0], 1'b0};
    end

    // Big is never smaller than small, so the difference cannot go negative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            big_sig   <= '0;
            small_sig <= '0;
            d         <= '0;
            sum       <= '0;
            exp       <= '0;
            sign      <= 1'b0;
            eff_sub   <= 1'b0;
        end else begin
            if (load) begin
                big_sig   <= sig_of(big_op);
                small_sig <= sig_of(small_op);
                d         <= big_op.exp - small_op.exp;
                exp       <= big_op.exp;
                sign      <= big_op.sign;
                eff_sub   <= op_a.sign ^ op_b.sign;
            end else if (align_clear) begin
                small_sig <= '0;
            end else if (align_shift) begin
                small_sig <= small_sig >> 1;
                d         <= d - EXP_BITS'(1);
            end
            if (sum_en) begin
                sum <= adder_out;
            end else if (norm_right) begin
                sum <= shift_out;
                exp <= exp + EXP_BITS'(1);
            end else if (norm_left) begin
                sum <= shift_out;
                exp <= exp - EXP_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle floating-point add/subtract: captures operands, resolves
// specials, then walks the shared datapath through align, sum and normalize.
module fp_add_sequencer
    import fp::*;
#(
    parameter int ALIGN_SHORTCUT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  float a,
    input  float b,
    input  logic sub,
    output logic out_valid,
    input  logic out_ready,
    output float result,
    output logic busy
);

    seq_state_t               state;
    float                     op_a;
    float                     op_b;
    logic [EXP_BITS-1:0]      d;
    logic [FRACTION_BITS:0]   small_sig;
    logic [FRACTION_BITS:0]   small_shifted;
    logic [FRACTION_BITS+1:0] sum;
    logic [EXP_BITS-1:0]      exp;
    logic [EXP_BITS-1:0]      exp_inc;
    logic [EXP_BITS-1:0]      exp_dec;
    logic                     sign;
    logic                     shortcut;
    logic                     align_last;
    logic                     load, align_shift, align_clear, sum_en, norm_right, norm_left;

    fp_add_datapath datapath (
        .clk(clk), .rst_n(rst_n), .load(load), .align_shift(align_shift),
        .align_clear(align_clear), .sum_en(sum_en), .norm_right(norm_right),
        .norm_left(norm_left), .op_a(op_a), .op_b(op_b), .d(d),
        .small_sig(small_sig), .sum(sum), .exp(exp), .sign(sign)
    );

    // A shift of F+1 or more clears the whole significand, so skip the walk.
    always_comb begin
        shortcut      = (ALIGN_SHORTCUT != 0) && (d > EXP_BITS'(FRACTION_BITS));
        small_shifted = small_sig >> 1;
        align_last    = (d == EXP_BITS'(1)) || (small_shifted == '0);
        exp_inc       = exp + EXP_BITS'(1);
        exp_dec       = exp - EXP_BITS'(1);
        load          = (state == SWAP);
        align_clear   = (state == ALIGN) && shortcut;
        align_shift   = (state == ALIGN) && !shortcut;
        sum_en        = (state == SUM);
        norm_right    = (state == NORM) && sum[FRACTION_BITS+1];
        norm_left     = (state == NORM) && (sum != '0) && !sum[FRACTION_BITS+1]
                        && !sum[FRACTION_BITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a     <= a;
                    op_b     <= '{sign: b.sign ^ sub, exp: b.exp, frac: b.frac};
                    state    <= SWAP;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                SWAP: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    if (is_nan(op_a) || is_nan(op_b)) begin
                        result <= QNAN;
                    end else if (is_inf(op_a) && is_inf(op_b) && (op_a.sign != op_b.sign)) begin
                        result <= QNAN;
                    end else if (is_inf(op_a)) begin
                        result <= op_a;
                    end else if (is_inf(op_b)) begin
                        result <= op_b;
                    end else if (is_zero(op_a) && is_zero(op_b)) begin
                        result <= '{sign: op_a.sign & op_b.sign, exp: '0, frac: '0};
                    end else begin
                        out_valid <= 1'b0;
                        state     <= (op_a.exp == op_b.exp) ? SUM : ALIGN;
                    end
                end
                ALIGN: if (shortcut || align_last) state <= SUM;
                SUM: state <= NORM;
                NORM: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    if (sum == '0) begin
                        result <= '0;
                    end else if (sum[FRACTION_BITS+1]) begin
                        if (exp_inc == EXP_MAX)
                            result <= '{sign: sign, exp: EXP_MAX, frac: '0};
                        else
                            result <= '{sign: sign, exp: exp_inc, frac: sum[FRACTION_BITS:1]};
                    end else if (sum[FRACTION_BITS]) begin
                        result <= '{sign: sign, exp: exp, frac: sum[FRACTION_BITS-1:0]};
                    end else if (exp_dec == '0) begin
                        result <= '{sign: sign, exp: '0, frac: '0};
                    end else begin
                        state     <= NORM;
                        out_valid <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
